// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM states, scancode constants, direction encodings.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_REL   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int DIR_UP_BIT    = 3;
  localparam int DIR_DOWN_BIT  = 2;
  localparam int DIR_LEFT_BIT  = 1;
  localparam int DIR_RIGHT_BIT = 0;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  // Arrow scancode to one-hot direction; zero for anything that is not an arrow.
  function automatic logic [3:0] dir_of_code(input logic [7:0] code);
    case (code)
      SC_UP:    dir_of_code = DIR_UP;
      SC_DOWN:  dir_of_code = DIR_DOWN;
      SC_LEFT:  dir_of_code = DIR_LEFT;
      SC_RIGHT: dir_of_code = DIR_RIGHT;
      default:  dir_of_code = 4'b0000;
    endcase
  endfunction

  // Direction pointing the other way along the same axis.
  function automatic logic [3:0] dir_opposite(input logic [3:0] d);
    case (d)
      DIR_UP:    dir_opposite = DIR_DOWN;
      DIR_DOWN:  dir_opposite = DIR_UP;
      DIR_LEFT:  dir_opposite = DIR_RIGHT;
      DIR_RIGHT: dir_opposite = DIR_LEFT;
      default:   dir_opposite = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_clock_filter.sv
// Synchronises the PS/2 lines and debounces the clock; emits a one-cycle pulse on each
// filtered falling edge together with the synchronised data line.
module ps2_clock_filter #(
  parameter int C_filter = 4
) (
  input  logic clk_pixel,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_fall,
  output logic data_sync
);

  localparam int CW = $clog2(C_filter + 1);

  logic [1:0]    clk_meta;
  logic [1:0]    data_meta;
  logic          clk_filt;
  logic [CW-1:0] run_cnt;

  // Two-stage synchronisers (idle-high), then a run-length filter on the clock level.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      clk_meta  <= 2'b11;
      data_meta <= 2'b11;
      clk_filt  <= 1'b1;
      run_cnt   <= '0;
      clk_fall  <= 1'b0;
    end else begin
      clk_meta  <= {clk_meta[0], ps2_clk};
      data_meta <= {data_meta[0], ps2_data};
      clk_fall  <= 1'b0;
      if (clk_meta[1] != clk_filt) begin
        if (run_cnt == CW'(C_filter - 1)) begin
          clk_filt <= clk_meta[1];
          run_cnt  <= '0;
          clk_fall <= clk_filt;
        end else begin
          run_cnt <= run_cnt + 1'b1;
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

  assign data_sync = data_meta[1];

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0 prefixes into flags, and tracks
// a snake-style arrow direction that cannot reverse onto itself.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int C_filter  = 4,
  parameter int C_timeout = 25000
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       extended,
  output logic       released,
  output logic       rx_error,
  output logic [3:0] direction
);

  localparam int TW = $clog2(C_timeout + 1);

  logic          clk_fall;
  logic          data_s;
  ps2_state_e    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          pend_ext;
  logic          pend_rel;
  logic          frame_ok;
  logic [3:0]    dir_req;

  ps2_clock_filter #(.C_filter(C_filter)) u_filt (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .clk_fall  (clk_fall),
    .data_sync (data_s)
  );

  // Stop bit is the live sample; parity is odd over data plus parity bit.
  assign frame_ok = data_s & (^{shreg, par_bit});
  assign dir_req  = dir_of_code(shreg);

  // Frame FSM with an inactivity timeout that silently drops partial frames.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
    end else if (clk_fall) begin
      tmo_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (!data_s) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          shreg   <= {data_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= ST_PARITY;
        end
        ST_PARITY: begin
          par_bit <= data_s;
          state   <= ST_STOP;
        end
        default: state <= ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (tmo_cnt == TW'(C_timeout - 1)) begin
        state   <= ST_IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Byte decode at the stop-bit edge: prefixes, strobe, error pulse and direction.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      scancode       <= 8'h00;
      scancode_valid <= 1'b0;
      extended       <= 1'b0;
      released       <= 1'b0;
      rx_error       <= 1'b0;
      pend_ext       <= 1'b0;
      pend_rel       <= 1'b0;
      direction      <= DIR_RIGHT;
    end else begin
      scancode_valid <= 1'b0;
      rx_error       <= 1'b0;
      if (clk_fall && state == ST_STOP) begin
        if (!frame_ok) begin
          rx_error <= 1'b1;
          pend_ext <= 1'b0;
          pend_rel <= 1'b0;
        end else if (shreg == SC_EXT) begin
          pend_ext <= 1'b1;
        end else if (shreg == SC_REL) begin
          pend_rel <= 1'b1;
        end else begin
          scancode       <= shreg;
          extended       <= pend_ext;
          released       <= pend_rel;
          scancode_valid <= 1'b1;
          pend_ext       <= 1'b0;
          pend_rel       <= 1'b0;
          if (pend_ext && !pend_rel && dir_req != 4'b0000 &&
              dir_req != dir_opposite(direction))
            direction <= dir_req;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed plus randomised frames against a byte-level model of the key decoder.
module tb_ps2_key_rx;

  logic       clk_pixel = 1'b0;
  logic       reset     = 1'b1;
  logic       ps2_clk   = 1'b1;
  logic       ps2_data  = 1'b1;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       extended;
  logic       released;
  logic       rx_error;
  logic [3:0] direction;

  localparam int H = 12;  // half bit period in clk_pixel cycles

  ps2_key_rx dut (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .scancode       (scancode),
    .scancode_valid (scancode_valid),
    .extended       (extended),
    .released       (released),
    .rx_error       (rx_error),
    .direction      (direction)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [3:0] dir;
  } ev_t;

  ev_t cap_arr [0:255];
  int  cap_wr   = 0;
  int  err_seen = 0;

  // Record every strobe and error pulse observed away from the active edge.
  always @(negedge clk_pixel) begin
    if (scancode_valid) begin
      cap_arr[cap_wr % 256] = '{scancode, extended, released, direction};
      cap_wr = cap_wr + 1;
    end
    if (rx_error) err_seen = err_seen + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic       m_pe, m_pf;
  logic [3:0] m_dir;
  logic [7:0] m_code;
  logic       m_ext, m_rel;
  int         exp_n, exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pe = 1'b0; m_pf = 1'b0; m_dir = 4'b0001;
    m_code = 8'h00; m_ext = 1'b0; m_rel = 1'b0;
  endtask

  // Byte-level behaviour: prefixes accumulate, other bytes strobe and clear them.
  task automatic model_frame(input logic [7:0] b, input bit bad);
    logic [3:0] req, opp;
    exp_n = 0; exp_err = 0;
    if (bad) begin
      exp_err = 1; m_pe = 1'b0; m_pf = 1'b0;
    end else if (b == 8'hE0) begin
      m_pe = 1'b1;
    end else if (b == 8'hF0) begin
      m_pf = 1'b1;
    end else begin
      exp_n = 1; m_code = b; m_ext = m_pe; m_rel = m_pf;
      req = (b == 8'h75) ? 4'b1000 : (b == 8'h72) ? 4'b0100 :
            (b == 8'h6B) ? 4'b0010 : (b == 8'h74) ? 4'b0001 : 4'b0000;
      opp = {m_dir[2], m_dir[3], m_dir[0], m_dir[1]};
      if (m_pe && !m_pf && req != 4'b0000 && req != opp) m_dir = req;
      m_pe = 1'b0; m_pf = 1'b0;
    end
  endtask

  // Drive n frame bits LSB first; data changes while the clock is high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (H) @(negedge clk_pixel);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk_pixel);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic xfer(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int cw, ew;
    logic par;
    ev_t ev;
    cw  = cap_wr;
    ew  = err_seen;
    par = ~(^b) ^ bad_par;
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    repeat (H) @(negedge clk_pixel);
    ps2_data = 1'b1;
    model_frame(b, bad_par | bad_stop);
    check({tag, ".strobes"}, 32'(cap_wr - cw), 32'(exp_n));
    check({tag, ".errors"}, 32'(err_seen - ew), 32'(exp_err));
    if (exp_n == 1) begin
      ev = cap_arr[cw % 256];
      check({tag, ".code"}, 32'(ev.code), 32'(m_code));
      check({tag, ".ext"}, 32'(ev.ext), 32'(m_ext));
      check({tag, ".rel"}, 32'(ev.rel), 32'(m_rel));
      check({tag, ".dir_at_strobe"}, 32'(ev.dir), 32'(m_dir));
    end
    check({tag, ".dir"}, 32'(direction), 32'(m_dir));
    check({tag, ".held_code"}, 32'(scancode), 32'(m_code));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".scancode"}, 32'(scancode), 32'h00);
    check({tag, ".valid"}, 32'(scancode_valid), 32'h0);
    check({tag, ".ext"}, 32'(extended), 32'h0);
    check({tag, ".rel"}, 32'(released), 32'h0);
    check({tag, ".err"}, 32'(rx_error), 32'h0);
    check({tag, ".dir"}, 32'(direction), 32'h1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_pixel);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int cw, ew, idx;
    logic [7:0] b;
    bit bp, bs;
    model_reset();
    @(negedge clk_pixel);
    repeat (3) @(negedge clk_pixel);
    check_reset_outputs("por");
    reset = 1'b0;
    repeat (5) @(negedge clk_pixel);

    // Plain key, then extended up, then extended-up break.
    xfer("k1c", 8'h1C, 1'b0, 1'b0);
    xfer("e0a", 8'hE0, 1'b0, 1'b0);
    xfer("up", 8'h75, 1'b0, 1'b0);
    xfer("e0b", 8'hE0, 1'b0, 1'b0);
    xfer("f0b", 8'hF0, 1'b0, 1'b0);
    xfer("upbrk", 8'h75, 1'b0, 1'b0);

    // From reset: left is a reversal of right, down is accepted.
    do_reset();
    xfer("e0c", 8'hE0, 1'b0, 1'b0);
    xfer("left", 8'h6B, 1'b0, 1'b0);
    xfer("e0d", 8'hE0, 1'b0, 1'b0);
    xfer("down", 8'h72, 1'b0, 1'b0);

    // Parity error, then a good frame; E0 pending is wiped by the error.
    xfer("e0e", 8'hE0, 1'b0, 1'b0);
    xfer("badpar", 8'h1C, 1'b1, 1'b0);
    xfer("good1c", 8'h1C, 1'b0, 1'b0);
    xfer("badstop", 8'h33, 1'b0, 1'b1);

    // Partial frame abandoned by timeout; E0 pending must survive it.
    xfer("e0f", 8'hE0, 1'b0, 1'b0);
    cw = cap_wr; ew = err_seen;
    send_bits(11'b000_0001_0100, 5);
    ps2_data = 1'b1;
    repeat (26000) @(negedge clk_pixel);
    check("tmo.strobes", 32'(cap_wr - cw), 32'h0);
    check("tmo.errors", 32'(err_seen - ew), 32'h0);
    xfer("tmo.next", 8'h6B, 1'b0, 1'b0);

    // Short low glitches on the clock with data low must not start a frame.
    cw = cap_wr; ew = err_seen;
    ps2_data = 1'b0;
    repeat (H) @(negedge clk_pixel);
    ps2_clk = 1'b0;
    @(negedge clk_pixel);
    ps2_clk = 1'b1;
    repeat (H) @(negedge clk_pixel);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk_pixel);
    ps2_clk = 1'b1;
    repeat (H) @(negedge clk_pixel);
    ps2_data = 1'b1;
    check("glitch.strobes", 32'(cap_wr - cw), 32'h0);
    check("glitch.errors", 32'(err_seen - ew), 32'h0);
    xfer("glitch.next", 8'h1C, 1'b0, 1'b0);

    // Reset in the middle of a frame, then a clean frame.
    xfer("pre.e0", 8'hE0, 1'b0, 1'b0);
    xfer("pre.up", 8'h75, 1'b0, 1'b0);
    send_bits(11'b000_0011_0110, 5);
    reset = 1'b1;
    repeat (2) @(negedge clk_pixel);
    check_reset_outputs("midrst");
    reset = 1'b0;
    ps2_data = 1'b1;
    model_reset();
    repeat (H) @(negedge clk_pixel);
    xfer("post.rst", 8'h2A, 1'b0, 1'b0);

    // Randomised mix biased towards prefixes and arrows, with occasional corruption.
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 9);
      case (idx)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'h75;
        3: b = 8'h72;
        4: b = 8'h6B;
        5: b = 8'h74;
        default: b = 8'($urandom_range(0, 255));
      endcase
      idx = $urandom_range(0, 19);
      bp = (idx == 0);
      bs = (idx == 1);
      xfer("rnd", b, bp, bs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
